// File: rtl/jts16_obj_pkg.sv
// Shared object-layer constants for jts16_obj and its line buffer.
// Defaults match the System 16 sprite pixel and line timing.
package jts16_obj_pkg;

  localparam int OBJ_DW = 12;
  localparam int OBJ_AW = 9;
  localparam int OBJ_PW = 2;

  localparam logic [3:0] OBJ_ALPHA  = 4'h0;
  localparam logic [8:0] OBJ_HSTART = 9'ha2;
  localparam logic [8:0] OBJ_FSTART = 9'h1ff + 9'hc0 - 9'ha2;

  // A new pixel wins over transparency or an equal/lower priority
  function automatic logic prio_win(
    input logic en,
    input logic clear,
    input int   np,
    input int   op
  );
    return !en || clear || (np >= op);
  endfunction

endpackage

// File: rtl/jts16_obj_lbuf_bank.sv
// One line buffer bank: RMW read/commit port plus read-and-erase port.
// The erase port shares the single RAM write port; commits take priority.
module jts16_obj_lbuf_bank
  import jts16_obj_pkg::*;
#(
  parameter int         DW    = OBJ_DW,
  parameter int         AW    = OBJ_AW,
  parameter int         PW    = OBJ_PW,
  parameter logic [3:0] ALPHA = OBJ_ALPHA
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_prio,
  output logic [3:0]    rd_key,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_prio,
  input  logic [DW-1:0] wr_data,
  input  logic          er_en,
  input  logic [AW-1:0] er_addr,
  output logic [DW-1:0] er_data
);

  localparam int EW = PW + DW;
  localparam logic [EW-1:0] EBLANK =
    {{(EW-4){1'b0}}, ALPHA};

  logic [EW-1:0] mem [2**AW];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [EW-1:0] m_data;

  always_comb begin
    m_we   = wr_en | er_en;
    m_addr = er_addr;
    m_data = EBLANK;
    if (wr_en) begin
      m_addr = wr_addr;
      m_data = {wr_prio, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (m_we)
      mem[m_addr] <= m_data;
    if (rd_en) begin
      rd_prio <= mem[rd_addr][EW-1:DW];
      rd_key  <= mem[rd_addr][3:0];
    end
  end

  assign er_data = mem[er_addr][DW-1:0];

endmodule

// File: rtl/jts16_obj_linebuf.sv
// Double-banked sprite line buffer: priority-merged draw writes on one
// bank while the other is scanned out and erased behind the beam.
module jts16_obj_linebuf
  import jts16_obj_pkg::*;
#(
  parameter int          DW      = OBJ_DW,
  parameter int          AW      = OBJ_AW,
  parameter int          PW      = OBJ_PW,
  parameter logic [3:0]  ALPHA   = OBJ_ALPHA,
  parameter bit          PRIO_EN = 1'b1,
  parameter logic [AW-1:0] HSTART = AW'(OBJ_HSTART),
  parameter logic [AW-1:0] FSTART = AW'(OBJ_FSTART)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic [AW-1:0] hofs,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [PW-1:0] wr_prio,
  output logic [DW-1:0] rd_data
);

  localparam logic [DW-1:0] BLANK =
    {{(DW-4){1'b0}}, ALPHA};

  logic          wsel;
  logic          lhbl_l;
  logic [AW-1:0] hcnt;

  logic          s1_v;
  logic          s1_bank;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic [PW-1:0] s1_prio;

  logic          s2_v;
  logic          s2_bank;
  logic [AW-1:0] s2_addr;
  logic [PW-1:0] s2_prio;
  logic [3:0]    s2_key;

  logic [PW-1:0] bk_prio [2];
  logic [3:0]    bk_key  [2];
  logic [DW-1:0] bk_er   [2];

  logic          fwd;
  logic [PW-1:0] cur_prio;
  logic [3:0]    cur_key;
  logic          commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_l <= 1'b0;
      wsel   <= 1'b0;
    end else begin
      lhbl_l <= LHBL;
      if (lhbl_l && !LHBL)
        wsel <= ~wsel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hcnt <= '0;
    else if (!LHBL)
      hcnt <= (flip ? FSTART : HSTART) + hofs;
    else if (pxl_cen)
      hcnt <= flip ? hcnt - 1'b1 : hcnt + 1'b1;
  end

  // Transparent pixels never enter the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_bank <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s1_prio <= '0;
    end else begin
      s1_v    <= we && (wr_data[3:0] != ALPHA);
      s1_bank <= wsel;
      s1_addr <= wr_addr;
      s1_data <= wr_data;
      s1_prio <= wr_prio;
    end
  end

  // The previous commit is not yet visible in the RAM read data
  always_comb begin
    fwd = s2_v && (s2_bank == s1_bank)
               && (s2_addr == s1_addr);
    cur_prio = bk_prio[s1_bank];
    cur_key  = bk_key[s1_bank];
    if (fwd) begin
      cur_prio = s2_prio;
      cur_key  = s2_key;
    end
    commit = s1_v && prio_win(PRIO_EN,
                              cur_key == ALPHA,
                              int'(s1_prio),
                              int'(cur_prio));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_bank <= 1'b0;
      s2_addr <= '0;
      s2_prio <= '0;
      s2_key  <= '0;
    end else begin
      s2_v    <= commit;
      s2_bank <= s1_bank;
      s2_addr <= s1_addr;
      s2_prio <= s1_prio;
      s2_key  <= s1_data[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= BLANK;
    else if (!LHBL)
      rd_data <= BLANK;
    else if (pxl_cen)
      rd_data <= bk_er[~wsel];
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    jts16_obj_lbuf_bank #(
      .DW    (DW),
      .AW    (AW),
      .PW    (PW),
      .ALPHA (ALPHA)
    ) u_bank (
      .clk     (clk),
      .rd_en   (we && (wsel == 1'(i))),
      .rd_addr (wr_addr),
      .rd_prio (bk_prio[i]),
      .rd_key  (bk_key[i]),
      .wr_en   (commit && (s1_bank == 1'(i))),
      .wr_addr (s1_addr),
      .wr_prio (s1_prio),
      .wr_data (s1_data),
      .er_en   (LHBL && pxl_cen && (wsel != 1'(i))),
      .er_addr (hcnt),
      .er_data (bk_er[i])
    );
  end

endmodule
